// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them from address 0 upward.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the core.
module imem_loader #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_run
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_words_left;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_shift;
  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic w_accept;
  assign w_accept = in_valid && r_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_addr       <= '0;
      r_byte_idx   <= '0;
      r_shift      <= '0;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_done <= 1'b0;
            if (word_count <= DEPTH_W) begin
              r_words_left <= word_count;
              r_addr       <= '0;
              r_byte_idx   <= '0;
              r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_csum       <= '0;
`endif
              if (word_count != '0) begin
                r_state    <= S_LOAD;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b1;
              end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state    <= S_CHECK;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b1;
`else
                r_state    <= S_DONE;
                r_done     <= 1'b1;
`endif
              end
            end else begin
              // Oversize request: flag it and leave memory untouched.
              r_error <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], in_data};
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ in_data;
`endif
            if (r_byte_idx == 2'd3) begin
              r_state     <= S_WRITE;
              r_in_ready  <= 1'b0;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= {r_shift, in_data};
            end
          end
        end
        S_WRITE: begin
          r_addr       <= r_addr + 1'b1;
          r_words_left <= r_words_left - 1'b1;
          if (r_words_left == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= S_CHECK;
            r_in_ready <= 1'b1;
`else
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (in_data == r_csum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign cpu_run   = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checks write log, handshake levels and release timing.
// Checksum steps are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_run;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            log_cyc[$];
  logic [7:0]    bytes_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cycle);
      $display("write addr=%0d data=0x%08h cycle=%0d", mem_addr, mem_wdata, cycle);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] cnt);
    word_count = cnt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  // Feeds bytes_q, advancing only on a real handshake; gaps drops in_valid every other cycle.
  task automatic stream(input bit gaps);
    int i = 0;
    int budget = 0;
    bit phase = 1'b1;
    bit acc;
    while (i < bytes_q.size() && budget < 2000) begin
      in_data  = bytes_q[i];
      in_valid = gaps ? phase : 1'b1;
      phase    = ~phase;
      acc      = in_valid && in_ready;
      tick();
      if (acc) i++;
      budget++;
    end
    in_valid = 1'b0;
    check("stream_bytes_accepted", 32'(i), 32'(bytes_q.size()));
  endtask

  // Called in the final WRITE cycle; advances until the core should be released.
  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
    foreach (bytes_q[k]) cs ^= bytes_q[k];
    tick();
    check("check_in_ready", 32'(in_ready), 1);
    in_data  = cs;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`else
    tick();
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 0);
    check({tag, "_mem_we"},    32'(mem_we), 0);
    check({tag, "_mem_addr"},  32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_error"},     32'(error), 0);
    check({tag, "_cpu_run"},   32'(cpu_run), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Two-word load, in_valid always high
    clear_log();
    bytes_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    do_start(2);
    check("two_in_ready_n1", 32'(in_ready), 1);
    check("two_busy", 32'(busy), 1);
    stream(1'b0);
    check("two_we_last", 32'(mem_we), 1);
    check("two_run_during_write", 32'(cpu_run), 0);
    finish_load();
    check("two_cpu_run", 32'(cpu_run), 1);
    check("two_done", 32'(done), 1);
    check("two_busy_end", 32'(busy), 0);
    check("two_nwrites", 32'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      check("two_addr0", 32'(log_addr[0]), 0);
      check("two_data0", log_data[0], 32'h20080005);
      check("two_addr1", 32'(log_addr[1]), 1);
      check("two_data1", log_data[1], 32'h01095020);
      check("two_spacing", 32'(log_cyc[1] - log_cyc[0]), 5);
    end

    // Same stream with gaps, restarted from DONE
    clear_log();
    do_start(2);
    check("gap_done_cleared", 32'(done), 0);
    check("gap_busy", 32'(busy), 1);
    stream(1'b1);
    finish_load();
    check("gap_done", 32'(done), 1);
    check("gap_nwrites", 32'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      check("gap_data0", log_data[0], 32'h20080005);
      check("gap_addr1", 32'(log_addr[1]), 1);
      check("gap_data1", log_data[1], 32'h01095020);
    end

    // Full depth: byte k = (k*37+11) mod 256
    clear_log();
    bytes_q.delete();
    for (int k = 0; k < 128; k++) bytes_q.push_back(8'((k * 37 + 11) % 256));
    do_start(32);
    stream(1'b0);
    finish_load();
    check("full_done", 32'(done), 1);
    check("full_nwrites", 32'(log_addr.size()), 32);
    if (log_addr.size() == 32) begin
      check("full_data0", log_data[0], 32'h0B30557A);
      check("full_addr31", 32'(log_addr[31]), 31);
      check("full_data31", log_data[31], 32'hF71C4166);
    end

    // Oversize request
    clear_log();
    do_start(33);
    check("over_error", 32'(error), 1);
    check("over_in_ready", 32'(in_ready), 0);
    check("over_busy", 32'(busy), 0);
    in_valid = 1'b1; in_data = 8'h5A;
    tick(); tick(); tick();
    check("over_in_ready_hold", 32'(in_ready), 0);
    check("over_error_hold", 32'(error), 1);
    check("over_no_writes", 32'(log_addr.size()), 0);
    in_valid = 1'b0;

    // Reset after six bytes, then a clean one-word load
    bytes_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
    do_start(2);
    check("mid_error_cleared", 32'(error), 0);
    stream(1'b0);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    clear_log();
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_start(1);
    stream(1'b0);
    finish_load();
    check("after_rst_cpu_run", 32'(cpu_run), 1);
    check("after_rst_nwrites", 32'(log_addr.size()), 1);
    if (log_addr.size() == 1) begin
      check("after_rst_addr", 32'(log_addr[0]), 0);
      check("after_rst_data", log_data[0], 32'hAABBCCDD);
    end

    // Zero-word load
    clear_log();
    bytes_q.delete();
    do_start(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("zero_busy", 32'(busy), 1);
    check("zero_in_ready", 32'(in_ready), 1);
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`endif
    check("zero_cpu_run", 32'(cpu_run), 1);
    check("zero_no_writes", 32'(log_addr.size()), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_start(1);
    stream(1'b0);
    tick();
    in_data = 8'h44; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("cs_good_done", 32'(done), 1);
    check("cs_good_error", 32'(error), 0);
    do_start(1);
    stream(1'b0);
    tick();
    in_data = 8'h45; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("cs_bad_error", 32'(error), 1);
    check("cs_bad_cpu_run", 32'(cpu_run), 0);
    check("cs_bad_busy", 32'(busy), 0);
    check("cs_bad_in_ready", 32'(in_ready), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
